// File: rtl/present_key_sched.sv
// rtl/present_key_sched.sv - PRESENT key schedule engine streaming round keys K1..K(NUM_ROUNDS+1)
// Define KEY_SCHED_CACHE_EN to add the round-key cache and reverse-order REPLAY for decryption.
module present_key_sched #(
  parameter int KEY_W      = 80,
  parameter int NUM_ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  input  logic             replay_req,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [63:0]      rk_out,
  output logic [5:0]       rk_idx,
  output logic             rk_last,
  output logic             busy
);
  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS + 1);
  localparam int         XOR_LO   = (KEY_W == 128) ? 62 : 15;

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_key_sched: KEY_W must be 80 or 128");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_rounds
    $error("present_key_sched: NUM_ROUNDS must be in 1..31");
  end

`ifdef KEY_SCHED_CACHE_EN
  typedef enum logic [1:0] {IDLE, GEN, REPLAY} state_t;
`else
  typedef enum logic {IDLE, GEN} state_t;
`endif

  state_t           state, state_nxt;
  logic [KEY_W-1:0] key_reg;
  logic [5:0]       i;
  logic             cache_valid;
  logic             hs;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [KEY_W-1:0] update(input logic [KEY_W-1:0] k, input logic [4:0] rc);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = sbox(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sbox(r[KEY_W-5 -: 4]);
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ rc;
    return r;
  endfunction

  assign hs   = rk_valid && rk_ready;
  assign busy = (state != IDLE);

`ifdef KEY_SCHED_CACHE_EN
  localparam int AW = $clog2(NUM_ROUNDS + 1);
  logic [63:0]   cache [NUM_ROUNDS+1];
  logic [AW-1:0] addr;

  assign addr = AW'(i - 6'd1);

  // Array contents survive reset; only cache_valid gates their use.
  always_ff @(posedge clk) begin
    if (state == GEN && rk_ready) cache[addr] <= key_reg[KEY_W-1 -: 64];
  end
`else
  logic unused_replay;
  assign unused_replay = ^{replay_req, cache_valid};
`endif

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    rk_out    = '0;
    rk_idx    = '0;
    rk_last   = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_nxt = GEN;
`ifdef KEY_SCHED_CACHE_EN
        else if (replay_req && cache_valid) state_nxt = REPLAY;
`endif
      end
      GEN: begin
        rk_valid = 1'b1;
        rk_out   = key_reg[KEY_W-1 -: 64];
        rk_idx   = i;
        rk_last  = (i == LAST_IDX);
        if (rk_ready && rk_last) state_nxt = IDLE;
      end
`ifdef KEY_SCHED_CACHE_EN
      REPLAY: begin
        rk_valid = 1'b1;
        rk_out   = cache[addr];
        rk_idx   = i;
        rk_last  = (i == 6'd1);
        if (rk_ready && rk_last) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      key_reg     <= '0;
      i           <= '0;
      cache_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (key_valid) begin
            key_reg     <= key_in;
            i           <= 6'd1;
            cache_valid <= 1'b0;
          end
`ifdef KEY_SCHED_CACHE_EN
          else if (replay_req && cache_valid) i <= LAST_IDX;
`endif
        end
        GEN: begin
          if (hs) begin
            if (i == LAST_IDX) cache_valid <= 1'b1;
            else begin
              key_reg <= update(key_reg, i[4:0]);
              i       <= i + 6'd1;
            end
          end
        end
`ifdef KEY_SCHED_CACHE_EN
        REPLAY: if (hs && i != 6'd1) i <= i - 6'd1;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_present_key_sched.sv
// tb/tb_present_key_sched.sv - bench for present_key_sched; 80-bit and 128-bit instances run in lockstep
// Replay scenarios are exercised when KEY_SCHED_CACHE_EN is defined.
module tb_present_key_sched;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic         replay_req = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] key_in = '0;

  logic        key_ready_a, rk_valid_a, rk_last_a, busy_a;
  logic [63:0] rk_out_a;
  logic [5:0]  rk_idx_a;
  logic        key_ready_b, rk_valid_b, rk_last_b, busy_b;
  logic [63:0] rk_out_b;
  logic [5:0]  rk_idx_b;

  int checks = 0;
  int failures = 0;
  logic [63:0] obs_a [1:32];
  logic [63:0] obs_b [1:32];
  logic [3:0]  sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  always #5 clk = ~clk;

  present_key_sched #(.KEY_W(80), .NUM_ROUNDS(31)) dut_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready_a), .key_in(key_in[79:0]),
    .replay_req(replay_req), .rk_valid(rk_valid_a), .rk_ready(rk_ready), .rk_out(rk_out_a),
    .rk_idx(rk_idx_a), .rk_last(rk_last_a), .busy(busy_a)
  );

  present_key_sched #(.KEY_W(128), .NUM_ROUNDS(31)) dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready_b), .key_in(key_in),
    .replay_req(replay_req), .rk_valid(rk_valid_b), .rk_ready(rk_ready), .rk_out(rk_out_b),
    .rk_idx(rk_idx_b), .rk_last(rk_last_b), .busy(busy_b)
  );

  // Round key n of a kw-bit key: apply the schedule step n-1 times to a masked wide integer.
  function automatic logic [63:0] ref_rk(input logic [127:0] key, input int kw, input int n);
    logic [127:0] k, mask;
    mask = (kw == 80) ? ((128'd1 << 80) - 128'd1) : '1;
    k = key & mask;
    for (int r = 1; r < n; r++) begin
      k = ((k << 61) | (k >> (kw - 61))) & mask;
      k[kw-1 -: 4] = sbox_t[k[kw-1 -: 4]];
      if (kw == 128) k[kw-5 -: 4] = sbox_t[k[kw-5 -: 4]];
      k = k ^ (128'(r % 32) << ((kw == 80) ? 15 : 62));
    end
    return k[kw-1 -: 64];
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode 0: plain; 1: random key_valid noise during the stream; 2: hold key_valid with next_key.
  task automatic run_stream(input logic [127:0] key, input int mode, input logic [127:0] next_key,
                            input string name);
    logic [63:0] ea, eb;
    key_in = key; key_valid = 1'b1; rk_ready = 1'b1; replay_req = 1'b0;
    checks++;
    if ({key_ready_a, key_ready_b} !== 2'b11) begin
      failures++; $display("FAIL %s key_ready got=%b%b exp=11", name, key_ready_a, key_ready_b);
    end
    @(negedge clk);
    key_valid = (mode == 2);
    if (mode == 2) key_in = next_key;
    for (int k = 1; k <= 32; k++) begin
      if (mode == 1) begin
        key_valid = (k < 32) ? 1'($urandom) : 1'b0;
        key_in = rand_key();
      end
      ea = ref_rk(key, 80, k);
      eb = ref_rk(key, 128, k);
      checks++;
      if ({rk_valid_a, rk_idx_a, rk_last_a, rk_out_a} !== {1'b1, 6'(k), k == 32, ea}) begin
        failures++;
        $display("FAIL %s k80 idx%0d got v=%b idx=%0d last=%b rk=%h exp v=1 idx=%0d last=%b rk=%h",
                 name, k, rk_valid_a, rk_idx_a, rk_last_a, rk_out_a, k, k == 32, ea);
      end
      checks++;
      if ({rk_valid_b, rk_idx_b, rk_last_b, rk_out_b} !== {1'b1, 6'(k), k == 32, eb}) begin
        failures++;
        $display("FAIL %s k128 idx%0d got v=%b idx=%0d last=%b rk=%h exp v=1 idx=%0d last=%b rk=%h",
                 name, k, rk_valid_b, rk_idx_b, rk_last_b, rk_out_b, k, k == 32, eb);
      end
      obs_a[k] = rk_out_a;
      obs_b[k] = rk_out_b;
      @(negedge clk);
    end
    checks++;
    if ({key_ready_a, busy_a, rk_valid_a, key_ready_b, busy_b, rk_valid_b} !== 6'b100100) begin
      failures++;
      $display("FAIL %s end_idle got rdy/busy/vld=%b%b%b %b%b%b exp=100 100", name,
               key_ready_a, busy_a, rk_valid_a, key_ready_b, busy_b, rk_valid_b);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0; key_valid = 1'b0; replay_req = 1'b0; rk_ready = 1'b1;
    while ((busy_a || busy_b) && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (busy_a || busy_b) begin
      failures++; $display("FAIL %s drain_timeout busy=%b%b exp=00", name, busy_a, busy_b);
    end
  endtask

  task automatic test_reset();
    #1;
    for (int p = 0; p < 2; p++) begin
      checks++;
      if ({rk_valid_a, rk_out_a, rk_idx_a, rk_last_a, busy_a, key_ready_a,
           rk_valid_b, rk_out_b, rk_idx_b, rk_last_b, busy_b, key_ready_b} !==
          {1'b0, 64'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 6'd0, 1'b0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL reset_state phase%0d got v=%b%b rk=%h/%h idx=%0d/%0d busy=%b%b rdy=%b%b exp v=00 rk=0 idx=0 busy=00 rdy=11",
                 p, rk_valid_a, rk_valid_b, rk_out_a, rk_out_b, rk_idx_a, rk_idx_b,
                 busy_a, busy_b, key_ready_a, key_ready_b);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_zero_key();
    run_stream('0, 0, '0, "zero");
    checks++;
    if ({obs_a[1], obs_a[2], obs_b[1], obs_b[2]} !==
        {64'h0, 64'hC000000000000000, 64'h0, 64'hCC00000000000000}) begin
      failures++;
      $display("FAIL zero_vectors got a=%h,%h b=%h,%h exp a=0,C000000000000000 b=0,CC00000000000000",
               obs_a[1], obs_a[2], obs_b[1], obs_b[2]);
    end
  endtask

  task automatic test_ones_key();
    run_stream('1, 0, '0, "ones");
    checks++;
    if ({obs_a[1], obs_a[2], obs_b[2]} !==
        {64'hFFFFFFFFFFFFFFFF, 64'h2FFFFFFFFFFFFFFF, 64'h22FFFFFFFFFFFFFF}) begin
      failures++;
      $display("FAIL ones_vectors got a=%h,%h b2=%h exp a=FFFFFFFFFFFFFFFF,2FFFFFFFFFFFFFFF b2=22FFFFFFFFFFFFFF",
               obs_a[1], obs_a[2], obs_b[2]);
    end
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 3; n++) run_stream(rand_key(), 1, '0, "random_noise");
  endtask

  task automatic test_backpressure();
    logic [127:0] key;
    logic [70:0]  held_a, held_b;
    key = rand_key();
    key_in = key; key_valid = 1'b1; rk_ready = 1'b1;
    @(negedge clk); key_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rk_ready = 1'b0;
    held_a = {rk_idx_a, rk_last_a, rk_out_a};
    held_b = {rk_idx_b, rk_last_b, rk_out_b};
    checks++;
    if ({held_a, held_b} !== {6'd3, 1'b0, ref_rk(key, 80, 3), 6'd3, 1'b0, ref_rk(key, 128, 3)}) begin
      failures++; $display("FAIL bp_k3 got a=%h b=%h exp idx=3 keys from model", held_a, held_b);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({rk_valid_a, rk_idx_a, rk_last_a, rk_out_a, rk_valid_b, rk_idx_b, rk_last_b, rk_out_b} !==
          {1'b1, held_a, 1'b1, held_b}) begin
        failures++;
        $display("FAIL bp_hold cyc%0d got a=%0d/%h b=%0d/%h exp a=%h b=%h", c,
                 rk_idx_a, rk_out_a, rk_idx_b, rk_out_b, held_a, held_b);
      end
    end
    rk_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rk_idx_a, rk_out_a, rk_idx_b, rk_out_b} !==
        {6'd4, ref_rk(key, 80, 4), 6'd4, ref_rk(key, 128, 4)}) begin
      failures++;
      $display("FAIL bp_k4 got a=%0d/%h b=%0d/%h exp idx=4 a=%h b=%h", rk_idx_a, rk_out_a,
               rk_idx_b, rk_out_b, ref_rk(key, 80, 4), ref_rk(key, 128, 4));
    end
    drain("backpressure");
  endtask

  task automatic test_back_to_back();
    logic [127:0] kx, ky;
    kx = rand_key(); ky = rand_key();
    run_stream(kx, 2, ky, "b2b_first");
    @(negedge clk);
    key_valid = 1'b0;
    checks++;
    if ({rk_valid_a, rk_idx_a, rk_out_a, rk_valid_b, rk_idx_b, rk_out_b} !==
        {1'b1, 6'd1, ref_rk(ky, 80, 1), 1'b1, 6'd1, ref_rk(ky, 128, 1)}) begin
      failures++;
      $display("FAIL b2b_second_k1 got v=%b%b idx=%0d/%0d rk=%h/%h exp v=11 idx=1 rk=%h/%h",
               rk_valid_a, rk_valid_b, rk_idx_a, rk_idx_b, rk_out_a, rk_out_b,
               ref_rk(ky, 80, 1), ref_rk(ky, 128, 1));
    end
    drain("back_to_back");
  endtask

  task automatic test_reset_midstream();
    key_in = rand_key(); key_valid = 1'b1; rk_ready = 1'b1;
    @(negedge clk); key_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if ({rk_idx_a, rk_idx_b} !== {6'd10, 6'd10}) begin
      failures++; $display("FAIL mid_idx got=%0d/%0d exp=10", rk_idx_a, rk_idx_b);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rk_valid_a, busy_a, key_ready_a, rk_valid_b, busy_b, key_ready_b} !== 6'b001001) begin
      failures++;
      $display("FAIL mid_reset got v/busy/rdy=%b%b%b %b%b%b exp=001 001", rk_valid_a, busy_a,
               key_ready_a, rk_valid_b, busy_b, key_ready_b);
    end
    @(negedge clk);
    rst = 1'b0; replay_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      replay_req = 1'b0;
      checks++;
      if ({rk_valid_a, busy_a, rk_valid_b, busy_b} !== 4'b0000) begin
        failures++;
        $display("FAIL post_reset_replay cyc%0d got v/busy=%b%b %b%b exp=00 00", c,
                 rk_valid_a, busy_a, rk_valid_b, busy_b);
      end
    end
  endtask

`ifdef KEY_SCHED_CACHE_EN
  task automatic run_replay(input logic [127:0] key, input string name);
    run_stream(key, 0, '0, name);
    replay_req = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    replay_req = 1'b0;
    for (int k = 32; k >= 1; k--) begin
      checks++;
      if ({rk_valid_a, rk_idx_a, rk_last_a, rk_out_a, rk_valid_b, rk_idx_b, rk_last_b, rk_out_b} !==
          {1'b1, 6'(k), k == 1, ref_rk(key, 80, k), 1'b1, 6'(k), k == 1, ref_rk(key, 128, k)}) begin
        failures++;
        $display("FAIL %s replay idx%0d got idx=%0d/%0d last=%b%b rk=%h/%h exp last=%b rk=%h/%h",
                 name, k, rk_idx_a, rk_idx_b, rk_last_a, rk_last_b, rk_out_a, rk_out_b,
                 k == 1, ref_rk(key, 80, k), ref_rk(key, 128, k));
      end
      obs_a[k] = rk_out_a;
      obs_b[k] = rk_out_b;
      @(negedge clk);
    end
    checks++;
    if ({busy_a, key_ready_a, busy_b, key_ready_b} !== 4'b0101) begin
      failures++;
      $display("FAIL %s replay_end got busy/rdy=%b%b %b%b exp=01 01", name, busy_a, key_ready_a,
               busy_b, key_ready_b);
    end
  endtask

  task automatic test_replay();
    logic [127:0] key;
    run_replay(rand_key(), "replay_rand");
    run_replay('0, "replay_zero");
    checks++;
    if ({obs_a[1], obs_b[1]} !== 128'd0) begin
      failures++; $display("FAIL replay_zero_final got=%h/%h exp=0", obs_a[1], obs_b[1]);
    end
    key = rand_key();
    key_in = key; key_valid = 1'b1; replay_req = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; replay_req = 1'b0;
    checks++;
    if ({rk_idx_a, rk_out_a, rk_idx_b, rk_out_b} !==
        {6'd1, ref_rk(key, 80, 1), 6'd1, ref_rk(key, 128, 1)}) begin
      failures++;
      $display("FAIL key_beats_replay got idx=%0d/%0d rk=%h/%h exp idx=1 rk=%h/%h", rk_idx_a,
               rk_idx_b, rk_out_a, rk_out_b, ref_rk(key, 80, 1), ref_rk(key, 128, 1));
    end
    drain("key_beats_replay");
  endtask
`endif

  initial begin
    test_reset();
    test_zero_key();
    test_ones_key();
    test_random_keys();
    test_backpressure();
    test_back_to_back();
`ifdef KEY_SCHED_CACHE_EN
    test_replay();
`endif
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
